calc_datapath_undo: RTL and testbench



---
 rtl/calc_pkg.sv | 15 +
 rtl/calc_datapath_undo_if.sv | 13 +
 rtl/calc_datapath_undo_mul.sv | 48 ++++
 rtl/calc_datapath_undo.sv | 86 ++++++++
 tb/tb_calc_datapath_undo.sv | 139 +++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared opcode, enable encodings and result width for the switch calculator
package calc_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4
  } opcode_t;
  localparam logic [2:0] EN_OP1  = 3'b011;
  localparam logic [2:0] EN_OP2  = 3'b101;
  localparam logic [2:0] EN_OPC  = 3'b110;
  localparam logic [2:0] EN_HOLD = 3'b111;
  localparam int RES_W = 17;
endpackage

// File: rtl/calc_datapath_undo_if.sv
// calc_datapath_undo_if: button/switch/enable bus from the control FSM and result back to it
// master = control FSM side, slave = datapath side
interface calc_datapath_undo_if #(parameter int WIDTH = 16);
  logic             BTNC;
  logic             BTNL;
  logic [WIDTH-1:0] SW;
  logic [2:0]       enable;
  logic [WIDTH:0]   resultado;
  logic             result_valid;
  logic             busy;
  modport master (output BTNC, BTNL, SW, enable, input resultado, result_valid, busy);
  modport slave  (input BTNC, BTNL, SW, enable, output resultado, result_valid, busy);
endinterface

// File: rtl/calc_datapath_undo_mul.sv
// seq_multiplier_16: shift-add multiplier, one multiplier bit per cycle LSB first, 17-bit truncated product
// ports: clk, reset, start (latch a/b), abort (drop work), a, b -> busy, done (1-cycle), p
module seq_multiplier_16
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] p
);
  logic [RES_W-1:0] r_a;
  logic [RES_W-1:0] r_acc;
  logic [15:0]      r_b;
  logic [3:0]       r_cnt;
  logic             r_busy;
  logic [RES_W-1:0] w_add;
  // done/p are combinational on the last iteration so the caller can register the product on that same edge
  assign w_add = r_acc + (r_b[0] ? r_a : '0);
  assign done  = r_busy && r_cnt == 4'd15;
  assign p     = w_add;
  assign busy  = r_busy;
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      r_busy <= 1'b0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (start) begin
      r_a    <= {1'b0, a};
      r_b    <= b;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc  <= w_add;
      r_a    <= r_a << 1;
      r_b    <= r_b >> 1;
      r_cnt  <= r_cnt + 4'd1;
      r_busy <= r_cnt != 4'd15;
    end
  end
endmodule

// File: rtl/calc_datapath_undo.sv
// calc_datapath_undo: operand/opcode capture with one-deep undo, ALU and sequential multiply for the calculator
// ports: clk, reset (sync, active-high), bus (slave: BTNC/BTNL/SW/enable in, resultado/result_valid/busy out)
module calc_datapath_undo
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  calc_datapath_undo_if.slave bus
);
  logic [WIDTH-1:0] r_op1, r_op2, r_op1_h, r_op2_h;
  logic [2:0]       r_opc, r_opc_h;
  logic [WIDTH:0]   r_res;
  logic             r_valid, r_pend;
  logic             w_btnc, w_btnl, w_hold, w_abort, w_ldc, w_start, w_mdone, w_mbusy;
  logic [WIDTH:0]   w_alu, w_p;
  // both buttons at once is not a valid event
  assign w_btnc  = bus.BTNC & ~bus.BTNL;
  assign w_btnl  = bus.BTNL & ~bus.BTNC;
  assign w_hold  = bus.enable == EN_HOLD;
  assign w_abort = (w_btnc | w_btnl) & w_hold;
  assign w_ldc   = w_btnc & (bus.enable == EN_OPC);
  assign w_start = w_ldc & (bus.SW[2:0] == OP_MUL);
  always_comb begin
    w_alu = r_opc == OP_ADD ? {1'b0, r_op1} + {1'b0, r_op2} :
            r_opc == OP_SUB ? {1'b0, r_op1} - {1'b0, r_op2} :
            r_opc == OP_AND ? {1'b0, r_op1 & r_op2} :
            r_opc == OP_OR  ? {1'b0, r_op1 | r_op2} : '0;
  end
  seq_multiplier_16 u_mul (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .abort (w_abort),
    .a     (r_op1),
    .b     (r_op2),
    .busy  (w_mbusy),
    .done  (w_mdone),
    .p     (w_p)
  );
  // undo targets the register loaded by the previous FSM step, hence the shifted enable mapping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op1   <= '0;
      r_op2   <= '0;
      r_op1_h <= '0;
      r_op2_h <= '0;
      r_opc   <= '0;
      r_opc_h <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      if (w_btnc && bus.enable == EN_OP1) begin
        r_op1_h <= r_op1;
        r_op1   <= bus.SW;
      end
      if (w_btnc && bus.enable == EN_OP2) begin
        r_op2_h <= r_op2;
        r_op2   <= bus.SW;
      end
      if (w_ldc) begin
        r_opc_h <= r_opc;
        r_opc   <= bus.SW[2:0];
      end
      if (w_btnl && bus.enable == EN_OP2) r_op1 <= r_op1_h;
      if (w_btnl && bus.enable == EN_OPC) r_op2 <= r_op2_h;
      if (w_btnl && w_hold) r_opc <= r_opc_h;
      r_pend <= w_ldc & ~w_start;
      if (w_abort) begin
        r_res   <= '0;
        r_valid <= 1'b0;
      end else if (r_pend) begin
        r_res   <= w_alu;
        r_valid <= 1'b1;
      end else if (w_mdone) begin
        r_res   <= w_p;
        r_valid <= 1'b1;
      end
    end
  end
  assign bus.resultado    = r_res;
  assign bus.result_valid = r_valid;
  assign bus.busy         = w_mbusy;
endmodule

// File: tb/tb_calc_datapath_undo.sv
// tb_calc_datapath_undo: directed vectors with hand-computed results for the calculator datapath
module tb_calc_datapath_undo;
  import calc_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  calc_datapath_undo_if #(.WIDTH(16)) bus ();
  calc_datapath_undo #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic c, input logic l, input logic [2:0] en, input logic [15:0] sw);
    bus.BTNC = c;
    bus.BTNL = l;
    bus.enable = en;
    bus.SW = sw;
    tick();
    bus.BTNC = 1'b0;
    bus.BTNL = 1'b0;
    bus.enable = EN_HOLD;
  endtask
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    press(1, 0, EN_HOLD, 16'h0);
    press(1, 0, EN_OP1, a);
    press(1, 0, EN_OP2, b);
    press(1, 0, EN_OPC, {13'b0, op});
  endtask
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [16:0] exp);
    int n;
    run_op(a, b, 3'd2);
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
    n = 0;
    while (bus.busy && n < 40) begin
      check({tag, "_rz"}, {15'b0, bus.result_valid, bus.resultado}, 32'd0);
      tick();
      n++;
    end
    check({tag, "_cycles"}, n, 32'd16);
    check({tag, "_valid"}, {31'b0, bus.result_valid}, 32'd1);
    check({tag, "_res"}, {15'b0, bus.resultado}, {15'b0, exp});
  endtask
  initial begin
    bit seen;
    bus.BTNC = 1'b0;
    bus.BTNL = 1'b0;
    bus.enable = EN_HOLD;
    bus.SW = '0;
    tick();
    tick();
    check("rst_res", {15'b0, bus.resultado}, 32'd0);
    check("rst_valid", {31'b0, bus.result_valid}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    reset = 1'b0;
    tick();
    press(1, 0, EN_OP1, 16'd7);
    press(1, 0, EN_OP2, 16'd9);
    press(0, 1, EN_OPC, 16'h0);
    check("undo_op2", {16'b0, dut.r_op2}, 32'd0);
    press(0, 1, EN_OPC, 16'h0);
    check("undo_op2_again", {16'b0, dut.r_op2}, 32'd0);
    press(1, 0, EN_OP2, 16'd2);
    press(1, 0, EN_OPC, 16'd0);
    tick();
    check("chain_res", {15'b0, bus.resultado}, 32'd9);
    check("chain_valid", {31'b0, bus.result_valid}, 32'd1);
    press(0, 1, EN_HOLD, 16'h0);
    check("undo_opc_valid", {31'b0, bus.result_valid}, 32'd0);
    check("undo_opc_res", {15'b0, bus.resultado}, 32'd0);
    check("undo_opc", {29'b0, dut.r_opc}, 32'd0);
    press(1, 0, EN_OP1, 16'd5);
    press(0, 1, EN_OPC, 16'h0);
    press(0, 1, EN_OP2, 16'h0);
    check("undo_op1", {16'b0, dut.r_op1}, 32'd7);
    press(0, 1, EN_OP1, 16'h0);
    check("undo_011_noop", {16'b0, dut.r_op1}, 32'd7);
    run_op(16'hFFFF, 16'h0001, 3'd0);
    check("add_busy", {31'b0, bus.busy}, 32'd0);
    tick();
    check("add_res", {15'b0, bus.resultado}, 32'h10000);
    check("add_valid", {31'b0, bus.result_valid}, 32'd1);
    run_op(16'd3, 16'd5, 3'd1);
    tick();
    check("sub_res", {15'b0, bus.resultado}, 32'h1FFFE);
    run_op(16'hF0F0, 16'hFF00, 3'd3);
    tick();
    check("and_res", {15'b0, bus.resultado}, 32'h0F000);
    run_op(16'hF0F0, 16'hFF00, 3'd4);
    tick();
    check("or_res", {15'b0, bus.resultado}, 32'h0FFF0);
    run_op(16'hF0F0, 16'hFF00, 3'd6);
    tick();
    check("op6_res", {15'b0, bus.resultado}, 32'd0);
    check("op6_valid", {31'b0, bus.result_valid}, 32'd1);
    run_mul("mul_300x200", 16'd300, 16'd200, 17'h0EA60);
    run_mul("mul_ffff", 16'hFFFF, 16'hFFFF, 17'h00001);
    run_mul("mul_1234x5", 16'h1234, 16'h0005, 17'h05B04);
    run_op(16'd300, 16'd200, 3'd2);
    repeat (3) tick();
    press(1, 0, EN_HOLD, 16'h0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= bus.result_valid;
    end
    check("abort_no_valid", {31'b0, seen}, 32'd0);
    press(1, 0, EN_OP1, 16'h00AA);
    press(1, 0, EN_OP1, 16'h0055);
    press(1, 1, EN_OP1, 16'h1234);
    check("both_op1", {16'b0, dut.r_op1}, 32'h0055);
    check("both_op1_h", {16'b0, dut.r_op1_h}, 32'h00AA);
    check("both_out", {14'b0, bus.busy, bus.result_valid, bus.resultado}, 32'd0);
    run_op(16'd300, 16'd200, 3'd2);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("rstmul_out", {14'b0, bus.busy, bus.result_valid, bus.resultado}, 32'd0);
    check("rstmul_op1", {16'b0, dut.r_op1}, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= bus.result_valid;
    end
    check("rstmul_no_valid", {31'b0, seen}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
